pixel_replication_zoom_engine: RTL

Sequential, parametrised successor to the combinational pixel-replication address mapper. On START it scans a full output frame for zoom factor 2^ZOOM_SHIFT (runtime-selectable), issues frame-buffer reads and absorbs the fixed read latency. It delivers replicated pixels with their output coordinates over a valid/ready stream with backpressure. It sits between the input frame buffer (160x120 by default) and the VGA output path.

---
 rtl/pixel_replication_zoom_engine.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_replication_zoom_engine.sv
// Streaming pixel-replication zoom: scans a 2^s-scaled output frame, reads the source frame buffer
// and emits replicated pixels with coordinates over valid/ready. Optional macro: PIXREP_STALL_CNT_EN.
module pixel_replication_zoom_engine #(
    parameter int IMG_WIDTH_IN  = 160,
    parameter int IMG_HEIGHT_IN = 120,
    parameter int PIX_W         = 8,
    parameter int ADDR_W        = 15,
    parameter int X_W           = 10,
    parameter int Y_W           = 9,
    parameter int MAX_SHIFT     = 2,
    parameter int MEM_LATENCY   = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [1:0]        ZOOM_SHIFT,
    output logic              R_EN,
    output logic [ADDR_W-1:0] R_ADDR,
    input  logic [PIX_W-1:0]  PIXEL_IN,
    output logic              VALID_OUT,
    input  logic              READY_OUT,
    output logic [PIX_W-1:0]  PIXEL_OUT,
    output logic [X_W-1:0]    X_OUT_COORD,
    output logic [Y_W-1:0]    Y_OUT_COORD,
    output logic              BUSY,
    output logic              DONE,
`ifdef PIXREP_STALL_CNT_EN
    output logic [15:0]       STALL_CNT,
`endif
    output logic              ERR
);

    localparam int FIFO_DEPTH = MEM_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        shift_q, shift_d;
    logic [X_W-1:0]    xo_q, xo_d;
    logic [Y_W-1:0]    yo_q, yo_d;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              pipe_v_q [MEM_LATENCY];
    logic [X_W-1:0]    pipe_x_q [MEM_LATENCY];
    logic [Y_W-1:0]    pipe_y_q [MEM_LATENCY];

    logic [PIX_W-1:0]  fifo_pix_q [FIFO_DEPTH];
    logic [X_W-1:0]    fifo_x_q   [FIFO_DEPTH];
    logic [Y_W-1:0]    fifo_y_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    int                inflight_s;
    int                wo_s, ho_s;
    logic              issue_s, accept_s, bad_shift_s, push_s, pop_s;
    logic [ADDR_W-1:0] raddr_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == FIFO_DEPTH - 1) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_ONE;
        end
    endfunction

    // Issue credit: reads in flight plus buffered pixels never exceed the FIFO depth.
    always_comb begin
        inflight_s = 0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight_s = inflight_s + int'(pipe_v_q[i]);
        end
        wo_s        = IMG_WIDTH_IN << shift_q;
        ho_s        = IMG_HEIGHT_IN << shift_q;
        issue_s     = (state_q == ST_RUN) && ((int'(cnt_q) + inflight_s) < FIFO_DEPTH);
        raddr_s     = ADDR_W'(((int'(yo_q) >> shift_q) * IMG_WIDTH_IN) + (int'(xo_q) >> shift_q));
        accept_s    = (state_q == ST_IDLE) && START && !done_q;
        bad_shift_s = (32'(ZOOM_SHIFT) > MAX_SHIFT);
        push_s      = pipe_v_q[MEM_LATENCY-1];
        pop_s       = VALID_OUT && READY_OUT;
    end

    // Frame scan FSM: next state, scan counters and status pulses.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && bad_shift_s) begin
                    err_d = 1'b1;
                end else if (accept_s) begin
                    shift_d = ZOOM_SHIFT;
                    xo_d    = {X_W{1'b0}};
                    yo_d    = {Y_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s && (int'(xo_q) == wo_s - 1)) begin
                    xo_d = {X_W{1'b0}};
                    if (int'(yo_q) == ho_s - 1) begin
                        state_d = ST_DRAIN;
                    end else begin
                        yo_d = yo_q + Y_W'(1);
                    end
                end else if (issue_s) begin
                    xo_d = xo_q + X_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((inflight_s == 0) && (cnt_q == {CNT_W{1'b0}})) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            shift_q <= 2'd0;
            xo_q    <= {X_W{1'b0}};
            yo_q    <= {Y_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (issue_s) begin
                addr_q <= raddr_s;
            end
        end
    end

    // Read-latency coordinate pipeline and output FIFO.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_v_q[i] <= 1'b0;
                pipe_x_q[i] <= {X_W{1'b0}};
                pipe_y_q[i] <= {Y_W{1'b0}};
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pix_q[i] <= {PIX_W{1'b0}};
                fifo_x_q[i]   <= {X_W{1'b0}};
                fifo_y_q[i]   <= {Y_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            pipe_v_q[0] <= issue_s;
            pipe_x_q[0] <= xo_q;
            pipe_y_q[0] <= yo_q;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_x_q[i] <= pipe_x_q[i-1];
                pipe_y_q[i] <= pipe_y_q[i-1];
            end
            if (push_s) begin
                fifo_pix_q[wr_ptr_q] <= PIXEL_IN;
                fifo_x_q[wr_ptr_q]   <= pipe_x_q[MEM_LATENCY-1];
                fifo_y_q[wr_ptr_q]   <= pipe_y_q[MEM_LATENCY-1];
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef PIXREP_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles where a valid pixel is held back by the sink.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_q <= 16'h0000;
        end else if (accept_s && !bad_shift_s) begin
            stall_q <= 16'h0000;
        end else if (BUSY && VALID_OUT && !READY_OUT && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end else begin
            stall_q <= stall_q;
        end
    end

    assign STALL_CNT = stall_q;
`endif

    assign R_EN        = issue_s;
    assign R_ADDR      = issue_s ? raddr_s : addr_q;
    assign VALID_OUT   = (cnt_q != {CNT_W{1'b0}});
    assign PIXEL_OUT   = fifo_pix_q[rd_ptr_q];
    assign X_OUT_COORD = fifo_x_q[rd_ptr_q];
    assign Y_OUT_COORD = fifo_y_q[rd_ptr_q];
    assign BUSY        = (state_q != ST_IDLE);
    assign DONE        = done_q;
    assign ERR         = err_q;

endmodule
